external_memory_arbiter: RTL

- Parametrised successor to the single serial-command memory port in the top level.
- Arbitrates NUM_REQ external requesters (serial command processor, debug/test masters) onto the processor's external memory control port, round-robin.
- Generates a registered, settled processor pause around every access and chains back-to-back requests without releasing pause.
- Adds a force_pause input for single-step debug; the old top level hard-wired pause to 0.

---
 rtl/external_memory_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/external_memory_arbiter.sv
// Round-robin arbiter for external requesters onto the processor's memory control port.
// Holds a registered, settled pause around every access and chains back-to-back grants without releasing it.
module external_memory_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MODE_WIDTH = 3,
  parameter logic [MODE_WIDTH-1:0] MODE_NONE = '0,
  parameter int PAUSE_SETTLE = 2,
  parameter int ACCESS_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             force_pause,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*MODE_WIDTH-1:0]    req_mode,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             pause,
  output logic                             externalMemoryControl,
  output logic [ADDR_WIDTH-1:0]            externalAddress,
  output logic [DATA_WIDTH-1:0]            externalData,
  output logic [MODE_WIDTH-1:0]            externalReadMode,
  output logic [MODE_WIDTH-1:0]            externalWriteMode,
  input  logic [DATA_WIDTH-1:0]            externalDataOut
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, ACCESS, RESPOND} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [IW-1:0]          gnt_q, gnt_d, ptr_q, ptr_d;
  logic                   write_q, write_d;
  logic [MODE_WIDTH-1:0]  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [DATA_WIDTH-1:0]  wdata_d, rdata_d;
  logic                   pause_d, ctrl_d, grab, drive;
  logic [MODE_WIDTH-1:0]  rmode_d, wmode_d;
  logic [NUM_REQ-1:0]     ready_d;
  logic                   arb_hit;
  logic [IW-1:0]          arb_idx, cand;

  // The requester just being acknowledged is masked so a held req_valid is not served twice.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!arb_hit && req_valid[cand] && !(state_q == RESPOND && cand == gnt_q)) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    write_d = write_q;
    mode_d  = mode_q;
    addr_d  = externalAddress;
    wdata_d = externalData;
    pause_d = pause;
    ctrl_d  = 1'b0;
    rmode_d = MODE_NONE;
    wmode_d = MODE_NONE;
    ready_d = '0;
    rdata_d = rsp_rdata;
    grab    = 1'b0;
    drive   = 1'b0;
    case (state_q)
      IDLE: begin
        pause_d = force_pause;
        if (arb_hit) begin
          grab = 1'b1;
          if (pause) begin
            state_d = ACCESS;
            drive   = 1'b1;
          end else begin
            pause_d = 1'b1;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == 8'(PAUSE_SETTLE - 1)) begin
          state_d = ACCESS;
          drive   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACCESS: begin
        if (cnt_q == 8'(ACCESS_LATENCY - 1)) begin
          state_d        = RESPOND;
          ready_d[gnt_q] = 1'b1;
          if (!write_q && mode_q != MODE_NONE) rdata_d = externalDataOut;
        end else begin
          cnt_d = cnt_q + 8'd1;
          drive = 1'b1;
        end
      end
      RESPOND: begin
        if (arb_hit) begin
          grab    = 1'b1;
          state_d = ACCESS;
          drive   = 1'b1;
        end else begin
          state_d = IDLE;
          pause_d = force_pause;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (grab) begin
      gnt_d   = arb_idx;
      ptr_d   = IW'((int'(arb_idx) + 1) % NUM_REQ);
      write_d = req_write[arb_idx];
      mode_d  = req_mode[arb_idx*MODE_WIDTH +: MODE_WIDTH];
      addr_d  = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
    end
    if (drive) begin
      ctrl_d = 1'b1;
      if (write_d) wmode_d = mode_d;
      else         rmode_d = mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q               <= IDLE;
      cnt_q                 <= '0;
      gnt_q                 <= '0;
      ptr_q                 <= '0;
      write_q               <= 1'b0;
      mode_q                <= MODE_NONE;
      pause                 <= 1'b0;
      externalMemoryControl <= 1'b0;
      externalAddress       <= '0;
      externalData          <= '0;
      externalReadMode      <= MODE_NONE;
      externalWriteMode     <= MODE_NONE;
      req_ready             <= '0;
      rsp_rdata             <= '0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      gnt_q                 <= gnt_d;
      ptr_q                 <= ptr_d;
      write_q               <= write_d;
      mode_q                <= mode_d;
      pause                 <= pause_d;
      externalMemoryControl <= ctrl_d;
      externalAddress       <= addr_d;
      externalData          <= wdata_d;
      externalReadMode      <= rmode_d;
      externalWriteMode     <= wmode_d;
      req_ready             <= ready_d;
      rsp_rdata             <= rdata_d;
    end
  end
endmodule
